// File: rtl/clk_divider.sv
// Programmable clock-enable divider: emits a one-cycle high pulse on clk_out
// once every max_in cycles of clk_in (max_in of 0 behaves like 1).
module clk_divider #(
  parameter int SIZE = 8
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic [SIZE-1:0] max_in,
  output logic            clk_out
);

  logic [SIZE-1:0] count;
  logic [SIZE-1:0] count_next;
  logic [SIZE-1:0] terminal;

  // terminal is M-1; the >= compare lets a lowered max_in wrap at once
  // instead of running the counter out through 2^SIZE.
  always_comb begin
    terminal   = '0;
    count_next = '0;
    if (max_in != '0) begin
      terminal = max_in - SIZE'(1);
    end
    if (count < terminal) begin
      count_next = count + SIZE'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      count   <= '0;
      clk_out <= 1'b0;
    end else begin
      count   <= count_next;
      clk_out <= (count_next == terminal);
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed scenarios plus random max_in
// and reset traffic, compared every cycle against a behavioural model.
module tb_clk_divider;

  localparam int SIZE = 8;

  logic            clk_in = 1'b0;
  logic            reset_n_in = 1'b0;
  logic [SIZE-1:0] max_in = 8'd100;
  logic            clk_out;

  int   vectors = 0;
  int   miscompares = 0;
  logic check_en = 1'b0;

  // Model state: phase is the number of edges into the current period.
  int   model_phase = 0;
  logic model_out = 1'b0;

  always #5 clk_in = ~clk_in;

  clk_divider #(.SIZE(SIZE)) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .max_in     (max_in),
    .clk_out    (clk_out)
  );

  function automatic int eff_ratio(input logic [SIZE-1:0] m);
    return (m == '0) ? 1 : int'(m);
  endfunction

  function automatic int next_phase(input int phase, input logic [SIZE-1:0] m);
    return (phase >= eff_ratio(m) - 1) ? 0 : phase + 1;
  endfunction

  always @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      model_phase <= 0;
      model_out   <= 1'b0;
    end else begin
      model_phase <= next_phase(model_phase, max_in);
      model_out   <= (next_phase(model_phase, max_in) == eff_ratio(max_in) - 1);
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: clk_out=%0b expected %0b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk_in) begin
    if (check_en) checkOutput("cycle", clk_out, model_out);
  end

  // Caller is aligned just after a falling edge; inputs change there, then
  // `cycles` rising edges are allowed to pass.
  task automatic applyStimulus(input logic rst_n, input logic [SIZE-1:0] m, input int cycles);
    reset_n_in = rst_n;
    max_in     = m;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic resetCycle(input logic [SIZE-1:0] m);
    applyStimulus(1'b0, m, 2);
  endtask

  initial begin
    int last_high;
    int high_count;
    int waited;
    @(negedge clk_in);
    check_en = 1'b1;

    applyStimulus(1'b0, 8'd100, 30);
    checkOutput("reset_hold", clk_out, 1'b0);

    applyStimulus(1'b1, 8'd100, 98);
    checkOutput("nom_e98", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd100, 1);
    checkOutput("nom_e99", clk_out, 1'b1);
    applyStimulus(1'b1, 8'd100, 1);
    checkOutput("nom_e100", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd100, 98);
    checkOutput("nom_e198", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd100, 1);
    checkOutput("nom_e199", clk_out, 1'b1);
    applyStimulus(1'b1, 8'd100, 1);
    checkOutput("nom_e200", clk_out, 1'b0);

    resetCycle(8'd1);
    applyStimulus(1'b1, 8'd1, 1);
    checkOutput("m1_e1", clk_out, 1'b1);
    applyStimulus(1'b1, 8'd1, 5);
    checkOutput("m1_e6", clk_out, 1'b1);

    resetCycle(8'd0);
    applyStimulus(1'b1, 8'd0, 1);
    checkOutput("m0_e1", clk_out, 1'b1);
    applyStimulus(1'b1, 8'd0, 5);
    checkOutput("m0_e6", clk_out, 1'b1);

    resetCycle(8'd2);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 8'd2, 1);
      checkOutput("m2_alt", clk_out, logic'(i % 2));
    end

    // Reset asserted while the pulse is high must drop clk_out before any edge.
    waited = 0;
    while (clk_out !== 1'b1 && waited < 4) begin
      @(negedge clk_in);
      waited++;
    end
    checkOutput("midpulse_seen", clk_out, 1'b1);
    #2 reset_n_in = 1'b0;
    #1 checkOutput("async_reset", clk_out, 1'b0);
    @(negedge clk_in);

    resetCycle(8'd100);
    applyStimulus(1'b1, 8'd100, 50);
    checkOutput("low_e50", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd10, 1);
    checkOutput("low_wrap", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd10, 8);
    checkOutput("low_e8", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd10, 1);
    checkOutput("low_pulse1", clk_out, 1'b1);
    applyStimulus(1'b1, 8'd10, 10);
    checkOutput("low_pulse2", clk_out, 1'b1);

    resetCycle(8'd10);
    applyStimulus(1'b1, 8'd10, 5);
    checkOutput("raise_e5", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd20, 4);
    checkOutput("raise_oldterm", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd20, 9);
    checkOutput("raise_e18", clk_out, 1'b0);
    applyStimulus(1'b1, 8'd20, 1);
    checkOutput("raise_pulse", clk_out, 1'b1);

    resetCycle(8'd255);
    applyStimulus(1'b1, 8'd255, 0);
    last_high  = -1;
    high_count = 0;
    for (int e = 1; e <= 3 * 255 + 5; e++) begin
      @(negedge clk_in);
      if (clk_out === 1'b1) begin
        if (last_high < 0) checkValue("full_first_edge", e, 254);
        else checkValue("full_spacing", e - last_high, 255);
        last_high = e;
        high_count++;
      end
    end
    checkValue("full_pulse_count", high_count, 3);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 8) max_in = SIZE'($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 2) max_in = SIZE'($urandom_range(200, 255));
      reset_n_in = ($urandom_range(0, 99) >= 4);
      if ($urandom_range(0, 99) < 3) begin
        #2 reset_n_in = 1'b0;
        #1 checkOutput("rand_async", clk_out, 1'b0);
        @(negedge clk_in);
      end else begin
        @(negedge clk_in);
      end
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
